// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: MD operation encoding and default MD latencies.
package mips_pkg;

   typedef enum logic [3:0] {
      MD_NONE = 4'd0,
      MULT    = 4'd1,
      MULTU   = 4'd2,
      DIV     = 4'd3,
      DIVU    = 4'd4,
      MFHI    = 4'd5,
      MFLO    = 4'd6,
      MTHI    = 4'd7,
      MTLO    = 4'd8
   } md_op_t;

   localparam int MULT_LAT_DEF = 5;
   localparam int DIV_LAT_DEF  = 10;

endpackage

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: architectural HI/LO plus a busy countdown
// that models multi-cycle MULT/DIV latency for the hazard unit.
module e_mdu
   import mips_pkg::*;
#(
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  md_op_t      md_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        start,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] md_rdata
);

   localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   localparam int CNT_W   = $clog2(MAX_LAT + 1);

   logic [CNT_W-1:0] cnt;
   logic [31:0]      tmp_hi, tmp_lo;

   logic [63:0] prod_s, prod_u;
   logic [31:0] abs_a, abs_b, sdiv_b, udiv_b;
   logic [31:0] uq_s, ur_s, q_s, r_s, q_u, r_u;
   logic        rt_zero;

   // Handshake with the hazard unit: start is a combinational request for the
   // op in E; it is only accepted on an edge where busy is low. While busy is
   // high every MD op (start, MTHI, MTLO) is dropped, so D must stall on
   // D_is_md && (start || busy).
   always_comb begin
      start = (md_op == MULT) || (md_op == MULTU) ||
              (md_op == DIV)  || (md_op == DIVU);

      md_rdata = 32'd0;
      case (md_op)
         MFHI:    md_rdata = hi;
         MFLO:    md_rdata = lo;
         default: md_rdata = 32'd0;
      endcase

      prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
      prod_u = {32'd0, rs_val} * {32'd0, rt_val};

      // Signed divide through magnitudes; 0x80000000 / -1 wraps back to 0x80000000.
      rt_zero = (rt_val == 32'd0);
      abs_a   = rs_val[31] ? (32'd0 - rs_val) : rs_val;
      abs_b   = rt_val[31] ? (32'd0 - rt_val) : rt_val;
      sdiv_b  = rt_zero ? 32'd1 : abs_b;
      udiv_b  = rt_zero ? 32'd1 : rt_val;
      uq_s    = abs_a / sdiv_b;
      ur_s    = abs_a % sdiv_b;
      q_s     = (rs_val[31] ^ rt_val[31]) ? (32'd0 - uq_s) : uq_s;
      r_s     = rs_val[31] ? (32'd0 - ur_s) : ur_s;
      q_u     = rs_val / udiv_b;
      r_u     = rs_val % udiv_b;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hi     <= 32'd0;
         lo     <= 32'd0;
         busy   <= 1'b0;
         cnt    <= '0;
         tmp_hi <= 32'd0;
         tmp_lo <= 32'd0;
      end else if (busy) begin
         cnt <= cnt - CNT_W'(1);
         if (cnt == CNT_W'(1)) begin
            hi   <= tmp_hi;
            lo   <= tmp_lo;
            busy <= 1'b0;
         end
      end else begin
         case (md_op)
            MULT: begin
               tmp_hi <= prod_s[63:32];
               tmp_lo <= prod_s[31:0];
               cnt    <= CNT_W'(MULT_LAT);
               busy   <= 1'b1;
            end
            MULTU: begin
               tmp_hi <= prod_u[63:32];
               tmp_lo <= prod_u[31:0];
               cnt    <= CNT_W'(MULT_LAT);
               busy   <= 1'b1;
            end
            // A zero divisor captures the current HI/LO so commit leaves them intact.
            DIV: begin
               tmp_hi <= rt_zero ? hi : r_s;
               tmp_lo <= rt_zero ? lo : q_s;
               cnt    <= CNT_W'(DIV_LAT);
               busy   <= 1'b1;
            end
            DIVU: begin
               tmp_hi <= rt_zero ? hi : r_u;
               tmp_lo <= rt_zero ? lo : q_u;
               cnt    <= CNT_W'(DIV_LAT);
               busy   <= 1'b1;
            end
            MTHI:    hi <= rs_val;
            MTLO:    lo <= rs_val;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu: a vector table of MD ops with hand-computed HI/LO
// and latency, plus sequences for busy-time drops and reset mid-operation.
module tb_e_mdu;
   import mips_pkg::*;

   logic        clk;
   logic        reset;
   md_op_t      md_op;
   logic [31:0] rs_val, rt_val;
   logic        start, busy;
   logic [31:0] hi, lo, md_rdata;

   int n_vec;
   int n_err;
   logic [31:0] exp_q[$];

   e_mdu dut (
      .clk      (clk),
      .reset    (reset),
      .md_op    (md_op),
      .rs_val   (rs_val),
      .rt_val   (rt_val),
      .start    (start),
      .busy     (busy),
      .hi       (hi),
      .lo       (lo),
      .md_rdata (md_rdata)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      md_op_t      op;
      logic [31:0] rs;
      logic [31:0] rt;
      logic        exp_start;
      int          exp_lat;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one op for a single cycle, then bubbles and counts busy cycles.
   task automatic issue(input md_op_t op, input logic [31:0] rs, input logic [31:0] rt,
                        output int lat);
      md_op  = op;
      rs_val = rs;
      rt_val = rt;
      step();
      md_op = MD_NONE;
      lat = 0;
      while (busy === 1'b1 && lat < 100) begin
         lat++;
         step();
      end
   endtask

   task automatic read_md(input md_op_t op, output logic [31:0] val);
      md_op = op;
      #1;
      val = md_rdata;
      md_op = MD_NONE;
      #1;
   endtask

   initial begin
      int          lat;
      logic [31:0] rd;
      logic [31:0] e;
      n_vec = 0;
      n_err = 0;

      vecs[0]  = '{MULT,    32'hFFFF_FFFF, 32'd2,         1'b1, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFE};
      vecs[1]  = '{MULTU,   32'hFFFF_FFFF, 32'd2,         1'b1, 5,  32'h0000_0001, 32'hFFFF_FFFE};
      vecs[2]  = '{DIV,     32'hFFFF_FFF9, 32'd2,         1'b1, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      vecs[3]  = '{DIVU,    32'd7,         32'd2,         1'b1, 10, 32'h0000_0001, 32'h0000_0003};
      vecs[4]  = '{DIV,     32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 10, 32'h0000_0000, 32'h8000_0000};
      vecs[5]  = '{DIV,     32'd7,         32'hFFFF_FFFE, 1'b1, 10, 32'h0000_0001, 32'hFFFF_FFFD};
      vecs[6]  = '{MTHI,    32'h0000_000A, 32'd0,         1'b0, 0,  32'h0000_000A, 32'hFFFF_FFFD};
      vecs[7]  = '{MTLO,    32'h0000_000B, 32'd0,         1'b0, 0,  32'h0000_000A, 32'h0000_000B};
      vecs[8]  = '{DIVU,    32'd100,       32'd0,         1'b1, 10, 32'h0000_000A, 32'h0000_000B};
      vecs[9]  = '{DIV,     32'hFFFF_FF00, 32'd0,         1'b1, 10, 32'h0000_000A, 32'h0000_000B};
      vecs[10] = '{MULT,    32'd3,         32'd4,         1'b1, 5,  32'h0000_0000, 32'h0000_000C};
      vecs[11] = '{MULT,    32'hFFFF_FFFD, 32'd4,         1'b1, 5,  32'hFFFF_FFFF, 32'hFFFF_FFF4};
      vecs[12] = '{MULTU,   32'h8000_0000, 32'h8000_0000, 1'b1, 5,  32'h4000_0000, 32'h0000_0000};
      vecs[13] = '{MD_NONE, 32'h1234_5678, 32'h9,         1'b0, 0,  32'h4000_0000, 32'h0000_0000};
      vecs[14] = '{md_op_t'(4'hC), 32'h1111_1111, 32'h2,  1'b0, 0,  32'h4000_0000, 32'h0000_0000};

      reset  = 1'b1;
      md_op  = MD_NONE;
      rs_val = 32'd0;
      rt_val = 32'd0;
      step();
      step();
      reset = 1'b0;

      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_rdata", md_rdata, 32'd0);

      foreach (vecs[i]) begin
         exp_q.push_back(vecs[i].exp_hi);
         exp_q.push_back(vecs[i].exp_lo);
         md_op  = vecs[i].op;
         rs_val = vecs[i].rs;
         rt_val = vecs[i].rt;
         #1;
         chk($sformatf("v%0d_start", i), {31'd0, start}, {31'd0, vecs[i].exp_start});
         issue(vecs[i].op, vecs[i].rs, vecs[i].rt, lat);
         chk($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
         e = exp_q.pop_front();
         chk($sformatf("v%0d_hi", i), hi, e);
         read_md(MFHI, rd);
         chk($sformatf("v%0d_mfhi", i), rd, e);
         e = exp_q.pop_front();
         chk($sformatf("v%0d_lo", i), lo, e);
         read_md(MFLO, rd);
         chk($sformatf("v%0d_mflo", i), rd, e);
      end

      // MTHI then MFHI in the following cycle
      md_op  = MTHI;
      rs_val = 32'h0000_1234;
      step();
      read_md(MFHI, rd);
      chk("mthi_mfhi", rd, 32'h0000_1234);

      // Ops presented while busy are dropped; no bypass of pending result
      md_op  = MULT;
      rs_val = 32'd5;
      rt_val = 32'd6;
      step();
      chk("b2b_busy", {31'd0, busy}, 32'd1);
      md_op  = MTLO;
      rs_val = 32'hDEAD_BEEF;
      step();
      md_op  = MTHI;
      rs_val = 32'hCAFE_F00D;
      step();
      md_op  = MULT;
      rs_val = 32'd9;
      rt_val = 32'd9;
      step();
      read_md(MFHI, rd);
      chk("busy_mfhi_old", rd, 32'h0000_1234);
      lat = 0;
      while (busy === 1'b1 && lat < 100) begin
         lat++;
         step();
      end
      chk("b2b_lat_rest", lat, 2);
      chk("b2b_hi", hi, 32'd0);
      chk("b2b_lo", lo, 32'd30);
      issue(MULT, 32'd3, 32'd4, lat);
      chk("b2b2_lat", lat, 5);
      chk("b2b2_hi", hi, 32'd0);
      chk("b2b2_lo", lo, 32'd12);

      // Reset during busy cycle 3 of a MULT discards the result
      md_op  = MTHI;
      rs_val = 32'h0000_0077;
      step();
      md_op  = MULT;
      rs_val = 32'd100;
      rt_val = 32'd200;
      step();
      md_op = MD_NONE;
      step();
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_hi", hi, 32'd0);
      chk("rst_mid_lo", lo, 32'd0);
      for (int k = 0; k < 8; k++) step();
      chk("rst_late_busy", {31'd0, busy}, 32'd0);
      chk("rst_late_hi", hi, 32'd0);
      chk("rst_late_lo", lo, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
